// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters.
//   Grants are round-robin and held for a whole message: the grantee keeps
//   the transmitter until it sends a byte flagged req_last, or until it has
//   kept req_valid low for IDLE_TIMEOUT consecutive cycles (0 = never).
//   A single registered output stage feeds the transmitter.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   req_data[8*N]       byte from requester i at [8i+7:8i]
//   req_valid[N]        requester i has a byte
//   req_last[N]         requester i's byte ends its message
//   req_ready[N]        requester i's byte is accepted this cycle
//   tx_data/tx_valid    to transmitter data_in / data_in_valid
//   tx_ready            from transmitter data_in_ready
//   grant_id            current or most recent grantee
//   busy                a grant is held
//   timeout             one-cycle pulse when the idle watchdog revokes a grant
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no grant; arbitrate among valid requesters, accept nothing
// ST_GRANT | grant_id owns the transmitter until last byte or watchdog

module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] IDLE_TIMEOUT = 16'd50000,
  localparam int         IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [15:0]    wdog_q, wdog_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           timeout_q, timeout_d;

  // round-robin scan
  int             scan_idx;
  logic [IDW-1:0] scan_sel;
  logic [IDW-1:0] winner;
  logic           found;

  logic           own_valid;
  logic           own_last;
  logic [7:0]     own_data;
  logic           accept;

  // Scan rr_ptr+1, rr_ptr+2, ... wrapping; the last grantee is checked last,
  // so a lone requester can still be re-granted after its own release.
  always_comb begin
    scan_idx = 0;
    scan_sel = '0;
    winner   = rr_ptr_q;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_sel = IDW'(scan_idx);
      if (!found && req_valid[scan_sel]) begin
        found  = 1'b1;
        winner = scan_sel;
      end
    end
  end

  // req_ready depends only on registered state, never on tx_ready.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_GRANT && !tx_valid_q) req_ready[grant_id_q] = 1'b1;
  end

  always_comb begin
    own_valid = req_valid[grant_id_q];
    own_last  = req_last[grant_id_q];
    own_data  = req_data[{grant_id_q, 3'b000} +: 8];
    accept    = own_valid && req_ready[grant_id_q];
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    wdog_d     = wdog_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    timeout_d  = 1'b0;

    // Output stage runs independently of the FSM, so leaving GRANT never
    // drops a byte that is still waiting for tx_ready.
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = own_data;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          rr_ptr_d   = winner;
          grant_id_d = winner;
          wdog_d     = '0;
        end
      end
      ST_GRANT: begin
        // A last-byte accept takes precedence over watchdog expiry.
        if (accept && own_last) begin
          state_d = ST_IDLE;
        end else begin
          if (own_valid) begin
            wdog_d = '0;
          end else if (wdog_q != 16'hFFFF) begin
            wdog_d = wdog_q + 16'd1;
          end
          if (IDLE_TIMEOUT != 16'd0 && wdog_d == IDLE_TIMEOUT) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      grant_id_q <= '0;
      wdog_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      wdog_q     <= wdog_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == ST_GRANT);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed cycle checks for reset, single byte, round-robin order, message
//   lock, backpressure, watchdog and mid-message reset, followed by random
//   message traffic checked against a message-level reference model
//   (per-requester message lists, round-robin grant prediction and an
//   expected byte stream).

module tb_uart_tx_arbiter;
  localparam int          N   = 4;
  localparam logic [15:0] TMO = 16'd8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [8*N-1:0]        req_data;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_last;
  logic [N-1:0]          req_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [$clog2(N)-1:0]  grant_id;
  logic                  busy;
  logic                  timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l, input logic v);
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
    req_valid[i]       = v;
  endtask

  // random-phase reference model state
  logic [7:0] mem [N][32];
  bit         lm  [N][32];
  int         wr [N];
  int         rd [N];
  int         low_run [N];
  logic [7:0] exp_q [$];
  int         rr_m;
  int         win;
  bit         prev_busy;
  logic [N-1:0] prev_valid;
  bit         done;
  int         cnt;
  int         p;
  bit         acc2;
  logic [7:0] msg2 [3];
  logic [31:0] exp_rdy;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;

    // reset values
    do_reset();
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_req_ready", req_ready, 0);

    // single byte
    tx_ready = 1'b1;
    set_req(1, 8'h41, 1'b1, 1'b1);                 // t0
    check_eq("sb_busy0", busy, 0);
    @(negedge clk);                                 // t1
    check_eq("sb_ready", req_ready, 4'b0010);
    check_eq("sb_busy1", busy, 1);
    @(negedge clk);                                 // t2
    req_valid[1] = 1'b0;
    check_eq("sb_tx_valid", tx_valid, 1);
    check_eq("sb_tx_data", tx_data, 8'h41);
    check_eq("sb_busy2", busy, 0);
    @(negedge clk);                                 // t3
    check_eq("sb_tx_clear", tx_valid, 0);

    // round-robin
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 1'b1, 1'b1);
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 5; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        check_eq($sformatf("rr_byte%0d", cnt), tx_data, 8'h10 + (cnt % 4));
        cnt++;
      end
    end
    check_eq("rr_count", cnt, 5);

    // message lock
    do_reset();
    tx_ready = 1'b1;
    msg2[0] = 8'hA0; msg2[1] = 8'hA1; msg2[2] = 8'hA2;
    p = 0; acc2 = 1'b0; cnt = 0;
    set_req(2, msg2[0], 1'b0, 1'b1);
    for (int c = 0; c < 80 && cnt < 4; c++) begin
      @(negedge clk);
      if (acc2) begin
        p++;
        if (p < 3) set_req(2, msg2[p], (p == 2), 1'b1);
        else req_valid[2] = 1'b0;
      end
      set_req(0, 8'h55, 1'b1, 1'b1);
      if (req_ready[2]) check_eq("ml_grant_id", grant_id, 2);
      if (tx_valid && tx_ready) begin
        check_eq($sformatf("ml_byte%0d", cnt), tx_data, (cnt < 3) ? (8'hA0 + cnt) : 8'h55);
        cnt++;
      end
      acc2 = req_valid[2] && req_ready[2];
    end
    check_eq("ml_count", cnt, 4);

    // backpressure
    do_reset();
    tx_ready = 1'b1;
    set_req(1, 8'h77, 1'b0, 1'b1);                 // t0
    @(negedge clk);                                 // t1
    check_eq("bp_ready0", req_ready, 4'b0010);
    @(negedge clk);                                 // t2
    set_req(1, 8'h78, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin              // t2..t21
      if (k > 0) @(negedge clk);
      tx_ready = 1'b0;
      check_eq("bp_valid", tx_valid, 1);
      check_eq("bp_data", tx_data, 8'h77);
      check_eq("bp_ready", req_ready, 0);
    end
    @(negedge clk);                                 // t22
    tx_ready = 1'b1;
    check_eq("bp_xfer_valid", tx_valid, 1);
    check_eq("bp_xfer_data", tx_data, 8'h77);
    @(negedge clk);                                 // t23
    check_eq("bp_after_valid", tx_valid, 0);
    check_eq("bp_after_ready", req_ready, 4'b0010);
    @(negedge clk);                                 // t24
    req_valid[1] = 1'b0;
    check_eq("bp_second_valid", tx_valid, 1);
    check_eq("bp_second_data", tx_data, 8'h78);
    check_eq("bp_second_busy", busy, 0);

    // watchdog
    do_reset();
    tx_ready = 1'b1;
    set_req(3, 8'h33, 1'b0, 1'b1);                 // t0
    @(negedge clk);                                 // t1
    check_eq("wd_grant3", grant_id, 3);
    check_eq("wd_ready3", req_ready, 4'b1000);
    @(negedge clk);                                 // t2: drop
    req_valid[3] = 1'b0;
    set_req(0, 8'h01, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin               // t2..t9
      if (k > 0) @(negedge clk);
      check_eq("wd_no_pulse", timeout, 0);
      check_eq("wd_busy", busy, 1);
    end
    @(negedge clk);                                 // t10
    check_eq("wd_pulse", timeout, 1);
    check_eq("wd_busy_fall", busy, 0);
    @(negedge clk);                                 // t11
    check_eq("wd_pulse_end", timeout, 0);
    check_eq("wd_regrant_busy", busy, 1);
    check_eq("wd_regrant_id", grant_id, 0);

    // mid-message reset
    do_reset();
    tx_ready = 1'b0;
    set_req(1, 8'hB0, 1'b0, 1'b1);                 // t0
    @(negedge clk);                                 // t1
    check_eq("mr_ready1", req_ready, 4'b0010);
    @(negedge clk);                                 // t2
    check_eq("mr_pending", tx_valid, 1);
    reset = 1'b1;
    @(negedge clk);                                 // t3
    reset = 1'b0;
    check_eq("mr_tx_valid", tx_valid, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_grant_id", grant_id, 0);
    check_eq("mr_ready", req_ready, 0);
    set_req(0, 8'hC0, 1'b1, 1'b1);
    @(negedge clk);                                 // t4
    check_eq("mr_prio_busy", busy, 1);
    check_eq("mr_prio_id", grant_id, 0);

    // random message traffic
    for (int round = 0; round < 3; round++) begin
      do_reset();
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        wr[i] = 0; rd[i] = 0; low_run[i] = 0;
        for (int m = 0, nm = $urandom_range(1, 4); m < nm; m++) begin
          for (int b = 0, len = $urandom_range(1, 4); b < len; b++) begin
            mem[i][wr[i]] = 8'($urandom);
            lm[i][wr[i]]  = (b == len - 1);
            wr[i]++;
          end
        end
      end
      rr_m = N - 1; prev_busy = 1'b0; prev_valid = '0; done = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          if (rd[i] < wr[i] && (low_run[i] >= 3 || $urandom_range(0, 3) != 0)) begin
            set_req(i, mem[i][rd[i]], lm[i][rd[i]], 1'b1);
            low_run[i] = 0;
          end else begin
            set_req(i, 8'h00, 1'b0, 1'b0);
            low_run[i]++;
          end
        end
        tx_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (busy && !prev_busy) begin
          win = -1;
          for (int k = 1; k <= N; k++)
            if (win < 0 && prev_valid[(rr_m + k) % N]) win = (rr_m + k) % N;
          check_eq("rnd_grant", grant_id, win);
          if (win >= 0) begin
            rr_m = win;
            for (int b = rd[win]; b < wr[win]; b++) begin
              exp_q.push_back(mem[win][b]);
              if (lm[win][b]) break;
            end
          end
        end
        check_eq("rnd_timeout", timeout, 0);
        exp_rdy = (busy && !tx_valid) ? (32'd1 << grant_id) : 32'd0;
        check_eq("rnd_ready", req_ready, exp_rdy);
        if (tx_valid && tx_ready) begin
          check_eq("rnd_expected_pending", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check_eq("rnd_data", tx_data, exp_q.pop_front());
        end
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) rd[i]++;
        prev_busy  = busy;
        prev_valid = req_valid;
        done = (exp_q.size() == 0) && !tx_valid && !busy;
        for (int i = 0; i < N; i++) if (rd[i] != wr[i]) done = 1'b0;
      end
      check_eq("rnd_drained", done, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single on-chip UART transmitter among `NUM_REQ` byte-stream requesters, e.g. the CPU MMIO path, a debug monitor and a DMA log channel.
- Grants are round-robin and message-locked: once a requester is granted, it keeps the transmitter until it sends a byte flagged `req_last`, or until its idle watchdog expires.
- Sits between the requesters and the transmitter's `data_in`/`data_in_valid`/`data_in_ready` ports.
- Uses a one-entry registered output stage.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `IDLE_TIMEOUT`, 16'd50000: consecutive cycles a granted requester may hold `req_valid` low before the grant is revoked. 0 disables the watchdog.
- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `req_data` input 8*NUM_REQ: byte from requester i, at bits [8i+7:8i].
- `req_valid` input NUM_REQ: requester i has a byte.
- `req_last` input NUM_REQ: requester i's current byte ends its message.
- `req_ready` output NUM_REQ: byte from requester i is accepted this cycle.
- `tx_data` output 8: byte to the transmitter `data_in`.
- `tx_valid` output 1: drives the transmitter `data_in_valid`.
- `tx_ready` input 1: from the transmitter `data_in_ready`.
- `grant_id` output $clog2(NUM_REQ): index of the current or most recent grantee.
- `busy` output 1: high while in state GRANT.
- `timeout` output 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- **States:** IDLE and GRANT. Internal `rr_ptr` holds the last granted index.
- **IDLE:**
  - If any `req_valid` is high, pick the first asserted index scanning `rr_ptr+1`, `rr_ptr+2`, … modulo NUM_REQ.
  - Next cycle: state=GRANT, `grant_id`=`rr_ptr`=winner, watchdog counter=0.
  - No bytes are accepted in IDLE.
- **GRANT:**
  - `req_ready[grant_id]` = `!tx_valid`. All other `req_ready` bits = 0.
  - On accept (`req_valid[g]` && `req_ready[g]`): load `tx_data`=byte and set `tx_valid`=1 next cycle.
  - If that byte had `req_last`=1, the state returns to IDLE next cycle.
- **Output stage:**
  - `tx_valid` stays high until a cycle where `tx_ready`=1; it clears the following cycle.
  - `tx_data` is stable while `tx_valid` is high.
  - Leaving GRANT never drops a pending `tx_valid`.
- **Watchdog (GRANT only):**
  - Counter increments each cycle `req_valid[grant_id]`=0 and clears when it is 1.
  - Saturates at 16 bits.
  - When it reaches IDLE_TIMEOUT (and IDLE_TIMEOUT≠0): state→IDLE and `timeout` pulses for 1 cycle.
- **Re-arbitration while pending:** IDLE may re-arbitrate while `tx_valid` is still pending. The new grantee waits for `tx_valid` to clear, because its `req_ready` is gated.
- **Message boundaries:** bytes of one message are never interleaved with another requester's bytes.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=NUM_REQ-1 (requester 0 has first priority), `grant_id`=0, `busy`=0, `tx_valid`=0, `tx_data`=0, `timeout`=0, `req_ready`=0, watchdog=0.
- **Arbitration latency:** `req_valid` rises in IDLE at cycle t → GRANT and `busy` at t+1 → earliest accept at t+1 → `tx_valid` at t+2 → transmitter start at t+2 if `tx_ready`.
- **Throughput:** at most one byte per 2 cycles. This never limits the UART, since a byte takes 10 symbols.
- **Combinational path:** `req_ready` depends only on registered state and `tx_valid`; there is no combinational path from `tx_ready`.
- **Simultaneous last-byte and timeout:** if the accept of a `req_last` byte and watchdog expiry fall in the same cycle, the accept wins and `timeout` is not pulsed. In practice this cannot happen, because the counter clears on `req_valid`.
- **Requester drops `req_valid` mid-message:** no effect except that the watchdog counts.
- **Reset mid-byte:** all state returns to reset values on the next edge. The transmitter is reset by the same `reset`.
- **Single requester:** a lone requester can be re-granted after its own release; it is selected after scanning all others.

## Test plan
- **Single byte:** reset; req1 presents 0x41 with `req_last`=1 at t=0 → `req_ready[1]`=1 at t=1; `tx_valid`=1, `tx_data`=0x41 at t=2; with `tx_ready`=1 → `tx_valid`=0 at t=3 and `busy`=0 at t=2.
- **Round-robin:** all four requesters hold single-byte messages (0x10..0x13), `tx_ready` stuck 1 → `tx_data` order 0x10, 0x11, 0x12, 0x13, 0x10.
- **Message lock:** req2 sends a 3-byte message 0xA0, 0xA1, 0xA2 (last on 0xA2) while req0 is valid → all three req2 bytes appear before any req0 byte; `grant_id` stays 2.
- **Backpressure:** `tx_ready`=0 for 20 cycles after `tx_valid` rises → `tx_data` is stable and `req_ready` stays 0 for those 20 cycles; the byte transfers on the cycle `tx_ready` rises.
- **Watchdog:** IDLE_TIMEOUT=8; req3 is granted, sends one non-last byte, then drops `req_valid` → `timeout` pulses exactly 8 cycles after the drop, `busy` falls, and req0 is granted next.
- **Mid-message reset:** assert `reset` during a req1 message → next cycle `tx_valid`=0, `busy`=0, `grant_id`=0; after release, req0 has first priority.
